// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared state encoding, LFSR constants and default timing for the mole scheduler
package mole_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GAP,
    SPAWN,
    UP,
    HIT,
    MISS,
    OVER
  } state_t;

  // x^8 + x^6 + x^5 + x^4 + 1 as a tap mask on q[7:0]
  localparam int          LFSR_W    = 8;
  localparam logic [7:0]  LFSR_TAPS = 8'hB8;
  localparam logic [7:0]  LFSR_SEED = 8'h01;

  localparam int DEF_N_HOLES    = 9;
  localparam int DEF_GAP_CYCLES = 25_000_000;
  localparam int DEF_UP_CYCLES  = 100_000_000;
  localparam int DEF_MIN_UP     = 25_000_000;
  localparam int DEF_UP_STEP    = 5_000_000;
  localparam int DEF_MAX_MISS   = 3;
  localparam int DEF_SCORE_MAX  = 99;

endpackage

// File: rtl/mole_lfsr.sv
// rtl/mole_lfsr.sv - free-running 8-bit Fibonacci LFSR used to pick the next hole
module mole_lfsr
  import mole_pkg::*;
(
  input  logic              cin,
  input  logic              key0_n,
  output logic [LFSR_W-1:0] q
);

  logic fb;

  assign fb = ^(q & LFSR_TAPS);

  always_ff @(posedge cin or negedge key0_n) begin
    if (!key0_n) begin
      q <= LFSR_SEED;
    end else begin
      q <= {q[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/mole_scheduler.sv
// rtl/mole_scheduler.sv - whack-a-mole round sequencer; MOLE_SPEEDUP_EN shrinks the up window on each hit
module mole_scheduler
  import mole_pkg::*;
#(
  parameter int N_HOLES    = DEF_N_HOLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int UP_CYCLES  = DEF_UP_CYCLES,
  parameter int MIN_UP     = DEF_MIN_UP,
  parameter int UP_STEP    = DEF_UP_STEP,
  parameter int MAX_MISS   = DEF_MAX_MISS,
  parameter int SCORE_MAX  = DEF_SCORE_MAX
) (
  input  logic               cin,
  input  logic               key0_n,
  input  logic               start,
  input  logic [N_HOLES-1:0] btn,
  output logic [N_HOLES-1:0] mole,
  output logic [6:0]         score,
  output logic [3:0]         misses,
  output logic               hit_pulse,
  output logic               game_over,
  output logic               busy
);

  localparam int HW   = $clog2(N_HOLES);
  localparam int CMAX = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [7:0] N8 = 8'(N_HOLES);

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [CW-1:0]       up_time;
  logic [HW-1:0]       hole_q, hole_nx, h_base;
  logic [7:0]          h_mod;
  logic [N_HOLES-1:0]  btn_q, press;
  logic [LFSR_W-1:0]   lfsr;
  logic                start_game, gap_done, up_done, hit_now, last_miss;

  mole_lfsr u_lfsr (
    .cin    (cin),
    .key0_n (key0_n),
    .q      (lfsr)
  );

  assign press      = btn & ~btn_q;
  assign start_game = start && ((state == IDLE) || (state == OVER));
  assign gap_done   = (cnt == CW'(GAP_CYCLES - 1));
  assign up_done    = (cnt == up_time - CW'(1));
  assign hit_now    = press[hole_q];
  assign last_miss  = ((misses + 4'd1) == 4'(MAX_MISS));

  // hole_q doubles as prev_hole: it only changes in SPAWN
  always_comb begin
    h_mod  = lfsr % N8;
    h_base = HW'(h_mod);
    if (h_base == hole_q) begin
      hole_nx = (h_base == HW'(N_HOLES - 1)) ? '0 : h_base + HW'(1);
    end else begin
      hole_nx = h_base;
    end
  end

  always_ff @(posedge cin or negedge key0_n) begin
    if (!key0_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mole      = '0;
    hit_pulse = 1'b0;
    game_over = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = GAP;
      end
      GAP: begin
        busy = 1'b1;
        if (gap_done) state_nx = SPAWN;
      end
      SPAWN: begin
        busy     = 1'b1;
        state_nx = UP;
      end
      UP: begin
        busy = 1'b1;
        mole = N_HOLES'(1) << hole_q;
        if (hit_now) state_nx = HIT;
        else if (up_done) state_nx = MISS;
      end
      HIT: begin
        busy      = 1'b1;
        hit_pulse = 1'b1;
        state_nx  = GAP;
      end
      MISS: begin
        busy     = 1'b1;
        state_nx = last_miss ? OVER : GAP;
      end
      OVER: begin
        game_over = 1'b1;
        if (start) state_nx = GAP;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Only GAP and UP are timed; every state change restarts the count
  always_ff @(posedge cin or negedge key0_n) begin
    if (!key0_n) begin
      cnt    <= '0;
      btn_q  <= '0;
      hole_q <= '0;
      score  <= '0;
      misses <= '0;
    end else begin
      btn_q <= btn;
      if ((state_nx != state) || !((state == GAP) || (state == UP))) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (state == SPAWN) hole_q <= hole_nx;
      if (start_game) begin
        score  <= '0;
        misses <= '0;
      end else begin
        if ((state == HIT) && (score < 7'(SCORE_MAX))) score <= score + 7'd1;
        if (state == MISS) misses <= misses + 4'd1;
      end
    end
  end

`ifdef MOLE_SPEEDUP_EN
  always_ff @(posedge cin or negedge key0_n) begin
    if (!key0_n) begin
      up_time <= CW'(UP_CYCLES);
    end else if (start_game) begin
      up_time <= CW'(UP_CYCLES);
    end else if (state == HIT) begin
      if (int'(up_time) >= MIN_UP + UP_STEP) up_time <= up_time - CW'(UP_STEP);
      else up_time <= CW'(MIN_UP);
    end
  end
`else
  assign up_time = CW'(UP_CYCLES);
`endif

endmodule

// File: tb/tb_mole_scheduler.sv
// tb/tb_mole_scheduler.sv - directed self-checking bench for mole_scheduler (honours MOLE_SPEEDUP_EN)
module tb_mole_scheduler;

  logic       cin    = 1'b0;
  logic       key0_n = 1'b0;
  logic       start  = 1'b0;
  logic [8:0] btn    = '0;
  logic [8:0] mole;
  logic [6:0] score;
  logic [3:0] misses;
  logic       hit_pulse, game_over, busy;

  int checks = 0;
  int errors = 0;
  int prev_m = 0;
  int exp_up = 20;
  int h, n;
  logic [7:0] lm = 8'h01;
  logic [7:0] lm_prev = 8'h01;

  always #5 cin = ~cin;

  always @(posedge cin or negedge key0_n) begin
    if (!key0_n) begin
      lm      = 8'h01;
      lm_prev = 8'h01;
    end else begin
      lm_prev = lm;
      lm      = {lm[6:0], ^(lm & 8'hB8)};
    end
  end

  mole_scheduler #(
    .N_HOLES    (9),
    .GAP_CYCLES (4),
    .UP_CYCLES  (20),
    .MIN_UP     (8),
    .UP_STEP    (4),
    .MAX_MISS   (3),
    .SCORE_MAX  (99)
  ) dut (
    .cin       (cin),
    .key0_n    (key0_n),
    .start     (start),
    .btn       (btn),
    .mole      (mole),
    .score     (score),
    .misses    (misses),
    .hit_pulse (hit_pulse),
    .game_over (game_over),
    .busy      (busy)
  );

  task automatic tick;
    @(posedge cin);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [7:0] v);
    int r;
    r = int'(v) % 9;
    if (r == prev_m) r = (r + 1) % 9;
    prev_m = r;
    return r;
  endfunction

  task automatic after_hit;
`ifdef MOLE_SPEEDUP_EN
    exp_up = (exp_up - 4 >= 8) ? exp_up - 4 : 8;
`endif
  endtask

  task automatic wait_mole(input string tag);
    int k;
    k = 0;
    while (mole == '0 && k < 40) begin
      tick;
      k++;
    end
    chk({tag, "_rose"}, 32'(mole != '0), 32'd1);
    h = pick(lm_prev);
    chk({tag, "_hole"}, 32'(mole), 32'(9'b1 << h));
  endtask

  task automatic measure_up(output int cnt_up);
    cnt_up = 1;
    for (int k = 0; k < 60; k++) begin
      tick;
      if (mole == '0) break;
      cnt_up++;
    end
  endtask

  initial begin
    tick;
    tick;
    chk("rst_mole", 32'(mole), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_misses", 32'(misses), 0);
    chk("rst_hit", 32'(hit_pulse), 0);
    chk("rst_over", 32'(game_over), 0);
    chk("rst_busy", 32'(busy), 0);
    key0_n = 1'b1;
    tick;
    tick;
    chk("idle_busy", 32'(busy), 0);

    // start latency: GAP x4, SPAWN, then mole
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_busy", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      chk("gap_dark", 32'(mole), 0);
      tick;
    end
    h = pick(lm_prev);
    chk("first_hole", 32'(mole), 32'(9'b1 << h));

    // hit on UP cycle 5
    repeat (4) tick;
    chk("up5_still", 32'(mole), 32'(9'b1 << h));
    btn[h] = 1'b1;
    tick;
    btn = '0;
    chk("hit_pulse", 32'(hit_pulse), 1);
    chk("hit_dark", 32'(mole), 0);
    tick;
    after_hit();
    chk("hit_pulse_off", 32'(hit_pulse), 0);
    chk("score_1", 32'(score), 1);
    for (int i = 0; i < 5; i++) begin
      chk("regap_dark", 32'(mole), 0);
      tick;
    end
    h = pick(lm_prev);
    chk("second_hole", 32'(mole), 32'(9'b1 << h));

    // unanswered mole
    measure_up(n);
    chk("miss1_window", 32'(n), 32'(exp_up));
    chk("miss1_pending", 32'(misses), 0);
    tick;
    chk("miss1_count", 32'(misses), 1);
    chk("miss1_busy", 32'(busy), 1);

    // button held from SPAWN, other holes pressed during UP
    repeat (4) tick;
    h = pick(lm);
    btn[h] = 1'b1;
    tick;
    chk("held_hole", 32'(mole), 32'(9'b1 << h));
    tick;
    btn[(h + 1) % 9] = 1'b1;
    tick;
    btn[(h + 1) % 9] = 1'b0;
    measure_up(n);
    chk("held_window", 32'(n + 2), 32'(exp_up));
    btn = '0;
    chk("held_score", 32'(score), 1);
    tick;
    chk("miss2_count", 32'(misses), 2);

    // press on final UP cycle
    wait_mole("final");
    repeat (exp_up - 1) tick;
    chk("final_still", 32'(mole), 32'(9'b1 << h));
    btn[h] = 1'b1;
    tick;
    btn = '0;
    chk("final_hit", 32'(hit_pulse), 1);
    tick;
    after_hit();
    chk("final_score", 32'(score), 2);
    chk("final_misses", 32'(misses), 2);

    // third miss ends the game
    wait_mole("third");
    measure_up(n);
    chk("miss3_window", 32'(n), 32'(exp_up));
    tick;
    chk("over_flag", 32'(game_over), 1);
    chk("over_busy", 32'(busy), 0);
    chk("over_misses", 32'(misses), 3);
    repeat (3) tick;
    chk("over_score_hold", 32'(score), 2);
    chk("over_mole", 32'(mole), 0);

    // new game from OVER
    start = 1'b1;
    tick;
    start = 1'b0;
    exp_up = 20;
    chk("restart_score", 32'(score), 0);
    chk("restart_misses", 32'(misses), 0);
    chk("restart_over", 32'(game_over), 0);
    wait_mole("rs");
    btn[h] = 1'b1;
    tick;
    btn = '0;
    tick;
    chk("rs_score", 32'(score), 1);

    // reset in the middle of UP
    wait_mole("mid");
    tick;
    #1;
    key0_n = 1'b0;
    #1;
    chk("mid_rst_mole", 32'(mole), 0);
    chk("mid_rst_score", 32'(score), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    prev_m = 0;
    tick;
    key0_n = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("post_rst_score", 32'(score), 0);

    // score saturation
    for (int i = 1; i <= 100; i++) begin
      wait_mole("sat");
      btn[h] = 1'b1;
      tick;
      btn = '0;
      tick;
      if (i >= 98) chk("sat_score", 32'(score), 32'((i < 99) ? i : 99));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Game sequencer for the whack-a-mole board: nine LED "holes" and nine push buttons.
- Runs the round FSM: gap, pick a random hole, light it, wait for a hit or a timeout, score or count a miss, end the game after MAX_MISS misses.
- Sits between the debounced button inputs and the LEDR/HEX drivers. Outputs a binary score to the existing BCD/7-seg display logic.

Parameters:
- N_HOLES, 9, number of LEDs/buttons (2..16).
- GAP_CYCLES, 25_000_000, dark cycles between moles (0.5 s at 50 MHz); must be ≥1.
- UP_CYCLES, 100_000_000, mole-up window in cycles (2 s at 50 MHz).
- MIN_UP, 25_000_000, floor on the up window (speed-up feature only).
- UP_STEP, 5_000_000, up-window reduction per hit (speed-up feature only).
- MAX_MISS, 3, misses that end the game (1..15).
- SCORE_MAX, 99, score saturation value.

Ports:
- cin  in  1  system clock, 50 MHz.
- key0_n  in  1  asynchronous active-low reset (KEY[0]).
- start  in  1  level, synchronous; acted on only in IDLE/OVER.
- btn  in  N_HOLES  debounced, synchronized button levels; 1 = pressed.
- mole  out  N_HOLES  one-hot LED drive; all zero when no mole is up.
- score  out  7  binary score, 0..SCORE_MAX.
- misses  out  4  miss count in the current game.
- hit_pulse  out  1  one-cycle strobe on each scored hit.
- game_over  out  1  high while in OVER.
- busy  out  1  high in GAP/SPAWN/UP/HIT/MISS.

Behaviour:
- Reset (key0_n=0, async): state IDLE. All outputs are 0. btn_q=0, prev_hole=0, LFSR=8'h01, up_time=UP_CYCLES, cycle counter=0.
- All state updates on rising edge of cin.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Free-runs every cycle, including IDLE. Never zero.
- Edge detect: btn_q <= btn; press = btn & ~btn_q. A button already held when a mole rises does not score.
- IDLE: start=1 clears score and misses, sets up_time=UP_CYCLES, goes to GAP.
- GAP: lasts exactly GAP_CYCLES cycles; mole=0. Then SPAWN.
- SPAWN: one cycle.
  - h = LFSR mod N_HOLES.
  - If h == prev_hole, h = (h+1) mod N_HOLES.
  - Latch hole=h and prev_hole=h; go to UP.
- UP: mole = one-hot(hole) from the first UP cycle. The counter counts UP cycles.
  - press[hole]=1 → HIT.
  - Else counter == up_time-1 → MISS (window is exactly up_time cycles).
  - Hit and timeout in the same cycle: hit wins.
  - Presses on other buttons are ignored.
- HIT: one cycle.
  - mole=0, hit_pulse=1.
  - score <= min(score+1, SCORE_MAX).
  - Go to GAP.
- MISS: one cycle.
  - mole=0, misses <= misses+1.
  - If misses+1 == MAX_MISS → OVER, else → GAP.
- OVER: game_over=1, mole=0; score and misses hold. start=1 behaves as in IDLE (new game).
- start is ignored in GAP/SPAWN/UP/HIT/MISS.
- Latency: start sampled at edge k gives GAP during k+1..k+GAP_CYCLES, SPAWN at k+GAP_CYCLES+1, mole high from k+GAP_CYCLES+2.
- Reset mid-game: immediate return to the reset state; mole drops asynchronously.
- Counter width: $clog2(max(UP_CYCLES, GAP_CYCLES)+1). No wrap, because the counter is cleared on every state change.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- With the macro defined: each HIT sets up_time <= max(up_time-UP_STEP, MIN_UP). up_time resets to UP_CYCLES on a new game. Subtraction must not underflow (compare before subtracting).
- Without the macro: up_time is constant at UP_CYCLES; MIN_UP and UP_STEP are unused; no extra registers.

Decomposition:
- Package mole_pkg holds:
  - the state enum (IDLE, GAP, SPAWN, UP, HIT, MISS, OVER);
  - LFSR width, taps and seed constants;
  - the default timing constants.
- One sub-module: mole_lfsr (free-running 8-bit LFSR; ports cin, key0_n, q[7:0]).
- Hole selection, FSM and counters stay in mole_scheduler.

Test Plan (N_HOLES=9, GAP_CYCLES=4, UP_CYCLES=20, MAX_MISS=3, MIN_UP=8, UP_STEP=4):
- Reset then start at edge k:
  - busy=1 from k+1;
  - exactly one mole bit high from k+6;
  - hole index = (LFSR at SPAWN) mod 9, after the repeat-avoid rule.
- Press btn[hole] on UP cycle 5:
  - hit_pulse one cycle;
  - score 0→1;
  - mole=0 next cycle;
  - next mole appears after 4 GAP + 1 SPAWN cycles.
- No press: mole stays high exactly 20 cycles, then misses=1. After the third miss: game_over=1, busy=0, score held.
- Hold btn[h] before the mole at hole h rises: no score. Press another hole's button during UP: no effect. Press on the final UP cycle: counted as a hit, not a miss.
- Reset mid-UP: mole=0 and all outputs 0 immediately. After start, score restarts at 0. With score forced to 99, a hit keeps it at 99.
- MOLE_SPEEDUP_EN defined: after successive hits the up window measures 20, 16, 12, 8, 8 cycles. Without the macro it is always 20.
